pipeline_hazard_ctrl: RTL and testbench

Pipeline control unit that drives the load and flush strobes of the four stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Freezes the whole pipe while instruction or data memory responses are outstanding.
- Inserts a one-cycle bubble on a load-use hazard.
- Squashes younger stages when the MEM stage resolves a taken branch or jump.
- Keeps saturating performance counters for stall, bubble and flush events.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 81 ++++++++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 24 ++
 rtl/pipeline_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared RV32I pipeline types used by the hazard/stall control slice.
// Holds the stall FSM encoding, the canonical NOP and the load-use check.
package rv32i_types;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } hazard_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic pc_load;
    logic pc_sel;
    logic if_id_load;
    logic id_ex_load;
    logic ex_mem_load;
    logic mem_wb_load;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_HOLD = '{default: 1'b0};

  localparam pipe_ctrl_t CTRL_ADVANCE = '{
    pc_load:      1'b1,
    pc_sel:       1'b0,
    if_id_load:   1'b1,
    id_ex_load:   1'b1,
    ex_mem_load:  1'b1,
    mem_wb_load:  1'b1,
    if_id_flush:  1'b0,
    id_ex_flush:  1'b0,
    ex_mem_flush: 1'b0
  };

  localparam pipe_ctrl_t CTRL_SQUASH = '{
    pc_load:      1'b1,
    pc_sel:       1'b1,
    if_id_load:   1'b1,
    id_ex_load:   1'b1,
    ex_mem_load:  1'b1,
    mem_wb_load:  1'b1,
    if_id_flush:  1'b1,
    id_ex_flush:  1'b1,
    ex_mem_flush: 1'b1
  };

  // PC and IF/ID hold the dependent instruction while a bubble enters EX.
  localparam pipe_ctrl_t CTRL_BUBBLE = '{
    pc_load:      1'b0,
    pc_sel:       1'b0,
    if_id_load:   1'b0,
    id_ex_load:   1'b1,
    ex_mem_load:  1'b1,
    mem_wb_load:  1'b1,
    if_id_flush:  1'b0,
    id_ex_flush:  1'b1,
    ex_mem_flush: 1'b0
  };

  function automatic logic load_use_hazard(
    input logic                  ex_mem_read,
    input logic [REG_ADDR_W-1:0] ex_rd,
    input logic [REG_ADDR_W-1:0] id_rs1,
    input logic [REG_ADDR_W-1:0] id_rs2,
    input logic                  uses_rs1,
    input logic                  uses_rs2
  );
    logic rs1_hit;
    logic rs2_hit;
    rs1_hit = uses_rs1 && (id_rs1 == ex_rd);
    rs2_hit = uses_rs2 && (id_rs2 == ex_rd);
    return ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping, so a long run
// never reports a misleadingly small figure.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic saturated;

  assign saturated = (count == {WIDTH{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !saturated) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline control: freezes on outstanding memory responses, inserts load-use
// bubbles, squashes on taken branches in MEM and counts each of those events.
module pipeline_hazard_ctrl
  import rv32i_types::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 imem_resp,
  input  logic                 dmem_resp,
  input  logic                 MEM_mem_read,
  input  logic                 MEM_mem_write,
  input  logic                 MEM_br_taken,
  input  logic                 EX_mem_read,
  input  logic [4:0]           EX_RD,
  input  logic [4:0]           ID_RS1,
  input  logic [4:0]           ID_RS2,
  input  logic                 ID_uses_rs1,
  input  logic                 ID_uses_rs2,
  output logic                 pc_load,
  output logic                 pc_sel,
  output logic                 if_id_load,
  output logic                 id_ex_load,
  output logic                 ex_mem_load,
  output logic                 mem_wb_load,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 ex_mem_flush,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] bubble_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  hazard_state_t state;
  logic          imem_done;
  logic          dmem_done;

  logic          mem_access;
  logic          i_ok;
  logic          d_ok;
  logic          advance;
  logic          hazard;
  pipe_ctrl_t    ctrl;

  logic          stall_inc;
  logic          bubble_inc;
  logic          flush_inc;

  assign mem_access = MEM_mem_read || MEM_mem_write;
  assign i_ok       = imem_resp || imem_done;
  assign d_ok       = !mem_access || dmem_resp || dmem_done;
  assign advance    = i_ok && d_ok;

  assign hazard = load_use_hazard(EX_mem_read, EX_RD, ID_RS1, ID_RS2,
                                  ID_uses_rs1, ID_uses_rs2);

  // Responses arriving while frozen are remembered until the pipe moves;
  // a response coinciding with advance is consumed on the spot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      imem_done <= 1'b0;
      dmem_done <= 1'b0;
    end else if (advance) begin
      state     <= RUN;
      imem_done <= 1'b0;
      dmem_done <= 1'b0;
    end else begin
      state <= WAIT;
      if (imem_resp) begin
        imem_done <= 1'b1;
      end
      if (dmem_resp) begin
        dmem_done <= 1'b1;
      end
    end
  end

  // A taken branch wins over a load-use hazard because the dependent
  // instruction in ID is squashed anyway.
  always_comb begin
    ctrl = CTRL_HOLD;
    if (!rst && advance) begin
      if (MEM_br_taken) begin
        ctrl = CTRL_SQUASH;
      end else if (hazard) begin
        ctrl = CTRL_BUBBLE;
      end else begin
        ctrl = CTRL_ADVANCE;
      end
    end
  end

  assign pc_load      = ctrl.pc_load;
  assign pc_sel       = ctrl.pc_sel;
  assign if_id_load   = ctrl.if_id_load;
  assign id_ex_load   = ctrl.id_ex_load;
  assign ex_mem_load  = ctrl.ex_mem_load;
  assign mem_wb_load  = ctrl.mem_wb_load;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_flush = ctrl.ex_mem_flush;

  assign stall_inc  = !rst && !advance;
  assign bubble_inc = !rst && advance && !MEM_br_taken && hazard;
  assign flush_inc  = !rst && advance && MEM_br_taken;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bubble_inc),
    .count (bubble_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_count)
  );

  // Latched responses only exist while frozen, so RUN never carries them.
  flags_only_in_wait: assert property (
    @(posedge clk) disable iff (rst)
      (state == RUN) |-> !(imem_done || dmem_done)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized self-checking bench for pipeline_hazard_ctrl with directed
// scenarios for memory freeze, load-use bubble, branch squash and saturation.
module tb_pipeline_hazard_ctrl;
  import rv32i_types::*;

  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_resp, dmem_resp;
  logic          MEM_mem_read, MEM_mem_write, MEM_br_taken;
  logic          EX_mem_read;
  logic [4:0]    EX_RD, ID_RS1, ID_RS2;
  logic          ID_uses_rs1, ID_uses_rs2;
  logic          pc_load, pc_sel, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
  logic          if_id_flush, id_ex_flush, ex_mem_flush;
  logic [CW-1:0] stall_cycles, bubble_count, flush_count;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: pending responses seen while frozen, plus event totals.
  bit m_valid = 1'b0;
  bit m_ipend, m_dpend;
  int m_stall, m_bubble, m_flush;

  pipeline_hazard_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_resp    (imem_resp),
    .dmem_resp    (dmem_resp),
    .MEM_mem_read (MEM_mem_read),
    .MEM_mem_write(MEM_mem_write),
    .MEM_br_taken (MEM_br_taken),
    .EX_mem_read  (EX_mem_read),
    .EX_RD        (EX_RD),
    .ID_RS1       (ID_RS1),
    .ID_RS2       (ID_RS2),
    .ID_uses_rs1  (ID_uses_rs1),
    .ID_uses_rs2  (ID_uses_rs2),
    .pc_load      (pc_load),
    .pc_sel       (pc_sel),
    .if_id_load   (if_id_load),
    .id_ex_load   (id_ex_load),
    .ex_mem_load  (ex_mem_load),
    .mem_wb_load  (mem_wb_load),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_flush (ex_mem_flush),
    .stall_cycles (stall_cycles),
    .bubble_count (bubble_count),
    .flush_count  (flush_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // Drive one cycle of inputs, compare against the model, then clock it.
  task automatic applyStimulus(input logic r, input logic im, input logic dm,
                               input logic mr, input logic mw, input logic br,
                               input logic exr, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2);
    bit   moving, dep;
    logic [8:0] exp_strobes;
    rst = r; imem_resp = im; dmem_resp = dm;
    MEM_mem_read = mr; MEM_mem_write = mw; MEM_br_taken = br;
    EX_mem_read = exr; EX_RD = rd; ID_RS1 = rs1; ID_RS2 = rs2;
    ID_uses_rs1 = u1; ID_uses_rs2 = u2;
    #4;
    moving = (im || m_ipend) && (!(mr || mw) || dm || m_dpend);
    dep    = exr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    // Order: pc_load pc_sel if_id id_ex ex_mem mem_wb | if_id_f id_ex_f ex_mem_f
    if (r || !moving)  exp_strobes = 9'b0_0_0000_000;
    else if (br)       exp_strobes = 9'b1_1_1111_111;
    else if (dep)      exp_strobes = 9'b0_0_0111_010;
    else               exp_strobes = 9'b1_0_1111_000;
    checkOutput("strobes",
                {55'd0, pc_load, pc_sel, if_id_load, id_ex_load, ex_mem_load,
                 mem_wb_load, if_id_flush, id_ex_flush, ex_mem_flush},
                {55'd0, exp_strobes});
    if (m_valid) begin
      checkOutput("stall_cycles", 64'(stall_cycles), 64'(m_stall));
      checkOutput("bubble_count", 64'(bubble_count), 64'(m_bubble));
      checkOutput("flush_count",  64'(flush_count),  64'(m_flush));
    end
    if (r) begin
      m_valid = 1'b1;
      m_ipend = 1'b0; m_dpend = 1'b0;
      m_stall = 0; m_bubble = 0; m_flush = 0;
    end else if (moving) begin
      m_ipend = 1'b0; m_dpend = 1'b0;
      if (br)       m_flush  = sat(m_flush + 1);
      else if (dep) m_bubble = sat(m_bubble + 1);
    end else begin
      m_ipend = m_ipend || im;
      m_dpend = m_dpend || dm;
      m_stall = sat(m_stall + 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle(input logic r, input logic im, input logic dm, input logic mr);
    applyStimulus(r, im, dm, mr, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; imem_resp = 1'b0; dmem_resp = 1'b0;
    MEM_mem_read = 1'b0; MEM_mem_write = 1'b0; MEM_br_taken = 1'b0;
    EX_mem_read = 1'b0; EX_RD = '0; ID_RS1 = '0; ID_RS2 = '0;
    ID_uses_rs1 = 1'b0; ID_uses_rs2 = 1'b0;
    @(posedge clk);
    #1;

    // Reset, then plain flow with an instruction every cycle.
    idleCycle(1'b1, 1'b0, 1'b0, 1'b0);
    idleCycle(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_state", 64'(dut.state), 64'(RUN));
    for (int i = 0; i < 4; i++) idleCycle(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("flow_stall_zero", 64'(stall_cycles), 64'd0);

    // Load in MEM waits for data; instruction arrives early and is held.
    idleCycle(1'b1, 1'b0, 1'b0, 1'b0);
    idleCycle(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("imem_done_latched", 64'(dut.imem_done), 64'd1);
    checkOutput("state_wait", 64'(dut.state), 64'(WAIT));
    idleCycle(1'b0, 1'b0, 1'b0, 1'b1);
    idleCycle(1'b0, 1'b0, 1'b0, 1'b1);
    idleCycle(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("stall_after_wait", 64'(stall_cycles), 64'd3);
    checkOutput("state_back_run", 64'(dut.state), 64'(RUN));
    checkOutput("imem_done_cleared", 64'(dut.imem_done), 64'd0);

    // Load-use on rs2, then the bubble clears it.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1);
    checkOutput("bubble_one", 64'(bubble_count), 64'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1);

    // Taken branch alongside the same hazard: squash wins.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1);
    checkOutput("flush_one", 64'(flush_count), 64'd1);
    checkOutput("bubble_unchanged", 64'(bubble_count), 64'd1);

    // Long freeze drives the stall counter into saturation.
    for (int i = 0; i < CMAX + 20; i++) idleCycle(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("stall_saturated", 64'(stall_cycles), 64'(CMAX));

    // Reset while frozen with a data response already latched.
    idleCycle(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("dmem_done_latched", 64'(dut.dmem_done), 64'd1);
    idleCycle(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_state_run", 64'(dut.state), 64'(RUN));
    checkOutput("rst_dmem_done", 64'(dut.dmem_done), 64'd0);
    checkOutput("rst_stall_zero", 64'(stall_cycles), 64'd0);
    idleCycle(1'b0, 1'b0, 1'b0, 1'b0);
    idleCycle(1'b0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic, narrow register range to provoke dependencies.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 1) == 1),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 1) == 1),
                    5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)),
                    ($urandom_range(0, 1) == 1),
                    ($urandom_range(0, 1) == 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
